// File: rtl/detect_disp_pkg.sv
// Shared constants for the detection counter display: segment patterns,
// digit strobe encodings and the counter width helper.
package detect_disp_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam int unsigned DP_BIT   = 7;

    localparam logic [1:0] DIG_UNITS = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/detect_count_display_seg7_decode.sv
// Combinational BCD nibble to 7-segment pattern (bit0=a .. bit6=g, active-high).
module seg7_decode
    import detect_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/detect_count_display.sv
// Counts rising edges of the detector match flag as two BCD digits and shows
// them on a time-multiplexed 7-segment display with a stretched decimal point.
module detect_count_display
    import detect_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned DP_STRETCH  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       det_in,
    input  logic       clr,
    output logic [7:0] seg_out,
    output logic [1:0] dig_sel,
    output logic [7:0] count_bcd,
    output logic       ovf
);

    localparam int unsigned REF_W = cnt_width(REFRESH_DIV);
    localparam int unsigned DP_W  = cnt_width(DP_STRETCH + 1);

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [DP_W-1:0]  DP_LOAD  = DP_W'(DP_STRETCH);

    if (REFRESH_DIV < 2) begin : g_bad_refresh
        $error("REFRESH_DIV must be at least 2");
    end
    if (DP_STRETCH < 1) begin : g_bad_stretch
        $error("DP_STRETCH must be at least 1");
    end

    logic [3:0]       units_q, units_d;
    logic [3:0]       tens_q, tens_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       dig_sel_q, dig_sel_d;
    logic [REF_W-1:0] refresh_q, refresh_d;
    logic [DP_W-1:0]  dp_cnt_q, dp_cnt_d;
    logic             det_prev_q, det_prev_d;

    logic             rise;
    logic             dp_lit;
    logic [3:0]       disp_nibble;
    logic [6:0]       seg_pat;

    assign rise = det_in & ~det_prev_q;

    always_comb begin
        units_d    = units_q;
        tens_d     = tens_q;
        ovf_d      = ovf_q;
        dig_sel_d  = dig_sel_q;
        refresh_d  = refresh_q;
        dp_cnt_d   = dp_cnt_q;
        det_prev_d = det_prev_q;

        if (ena) begin
            det_prev_d = det_in;

            if (refresh_q == REF_LAST) begin
                refresh_d = '0;
                dig_sel_d = (dig_sel_q == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
            end else begin
                refresh_d = refresh_q + REF_W'(1);
            end

            // clr wins over a coincident rise: that rise is dropped entirely.
            if (clr) begin
                units_d  = '0;
                tens_d   = '0;
                ovf_d    = 1'b0;
                dp_cnt_d = '0;
            end else if (rise) begin
                dp_cnt_d = DP_LOAD;
                if (units_q == 4'd9) begin
                    units_d = '0;
                    if (tens_q == 4'd9) begin
                        tens_d = '0;
                        ovf_d  = 1'b1;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    units_d = units_q + 4'd1;
                end
            end else if (dp_cnt_q != '0) begin
                dp_cnt_d = dp_cnt_q - DP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            units_q    <= '0;
            tens_q     <= '0;
            ovf_q      <= 1'b0;
            dig_sel_q  <= DIG_UNITS;
            refresh_q  <= '0;
            dp_cnt_q   <= '0;
            det_prev_q <= 1'b0;
        end else begin
            units_q    <= units_d;
            tens_q     <= tens_d;
            ovf_q      <= ovf_d;
            dig_sel_q  <= dig_sel_d;
            refresh_q  <= refresh_d;
            dp_cnt_q   <= dp_cnt_d;
            det_prev_q <= det_prev_d;
        end
    end

    assign dp_lit      = (dp_cnt_q != '0);
    assign disp_nibble = (dig_sel_q == DIG_UNITS) ? units_q : tens_q;

    seg7_decode u_seg7_decode (
        .bcd (disp_nibble),
        .seg (seg_pat)
    );

    // Tens digit is blanked when zero and never shows the decimal point.
    always_comb begin
        seg_out = SEG_BLANK;
        if (dig_sel_q == DIG_UNITS) begin
            seg_out         = {1'b0, seg_pat};
            seg_out[DP_BIT] = dp_lit;
        end else if (tens_q != 4'd0) begin
            seg_out = {1'b0, seg_pat};
        end
    end

    assign dig_sel   = dig_sel_q;
    assign count_bcd = {tens_q, units_q};
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_detect_count_display.sv
// Self-checking bench for detect_count_display: fixed vector table, directed
// corner sequences and randomized traffic against an integer reference model.
module tb_detect_count_display;

    localparam int unsigned RDIV = 4;
    localparam int unsigned DPS  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       det_in = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] seg_out;
    logic [1:0] dig_sel;
    logic [7:0] count_bcd;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    detect_count_display #(
        .REFRESH_DIV (RDIV),
        .DP_STRETCH  (DPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .det_in    (det_in),
        .clr       (clr),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .count_bcd (count_bcd),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model: plain integers for the count, DP time left and phase.
    logic [7:0] ref_pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    int m_count;
    bit m_ovf;
    int m_dp;
    int m_phase_cycles;
    bit m_tens_phase;
    bit m_prev;

    task automatic model_update(input logic r, input logic e, input logic c, input logic d);
        bit rose;
        if (r) begin
            m_count = 0; m_ovf = 0; m_dp = 0;
            m_phase_cycles = 0; m_tens_phase = 0; m_prev = 0;
        end else if (e) begin
            rose   = d && !m_prev;
            m_prev = d;
            m_phase_cycles++;
            if (m_phase_cycles == RDIV) begin
                m_phase_cycles = 0;
                m_tens_phase   = !m_tens_phase;
            end
            if (c) begin
                m_count = 0; m_ovf = 0; m_dp = 0;
            end else if (rose) begin
                m_count = (m_count + 1) % 100;
                if (m_count == 0) m_ovf = 1;
                m_dp = DPS;
            end else if (m_dp > 0) begin
                m_dp--;
            end
        end
    endtask

    function automatic logic [7:0] exp_count();
        return {4'(m_count / 10), 4'(m_count % 10)};
    endfunction

    function automatic logic [7:0] exp_seg();
        if (!m_tens_phase) return ref_pat[m_count % 10] | ((m_dp > 0) ? 8'h80 : 8'h00);
        if (m_count / 10 == 0) return 8'h00;
        return ref_pat[m_count / 10];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_count", count_bcd, exp_count());
        check("model_ovf", {7'd0, ovf}, {7'd0, m_ovf});
        check("model_dig_sel", {6'd0, dig_sel}, m_tens_phase ? 8'h02 : 8'h01);
        check("model_seg", seg_out, exp_seg());
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic d);
        rst = r; ena = e; clr = c; det_in = d;
        @(posedge clk);
        model_update(r, e, c, d);
        #1;
        compare_model();
    endtask

    task automatic pulse(input logic e);
        step(1'b0, e, 1'b0, 1'b1);
        step(1'b0, e, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       rst, ena, clr, det;
        logic [7:0] count;
        logic       ovf;
        logic [1:0] dig;
        logic [7:0] seg;
    } vec_t;

    vec_t vecs [21];

    initial begin
        logic [7:0] snap_seg;
        logic [1:0] snap_dig;

        // Reset, idle refresh, then det_in held high for 10 cycles.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h3F};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h3F};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h3F};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h3F};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h3F};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b10, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b10, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b10, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b10, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 8'h3F};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b01, 8'h86};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b01, 8'h86};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b01, 8'h86};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b10, 8'h00};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b10, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b10, 8'h00};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b10, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b01, 8'h06};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b01, 8'h06};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b01, 8'h06};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 2'b01, 8'h06};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].clr, vecs[i].det);
            check($sformatf("vec%0d_count", i), count_bcd, vecs[i].count);
            check($sformatf("vec%0d_ovf", i), {7'd0, ovf}, {7'd0, vecs[i].ovf});
            check($sformatf("vec%0d_dig", i), {6'd0, dig_sel}, {6'd0, vecs[i].dig});
            check($sformatf("vec%0d_seg", i), seg_out, vecs[i].seg);
        end

        // Twelve isolated pulses: units shows 2, tens shows 1.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) pulse(1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("multi_count", count_bcd, 8'h12);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (m_tens_phase) check("multi_tens_seg", seg_out, 8'h06);
            else              check("multi_units_seg", seg_out, 8'h5B);
        end

        // 100 pulses wrap to 00 with sticky ovf; clr drops ovf.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) pulse(1'b1);
        check("wrap_count", count_bcd, 8'h00);
        check("wrap_ovf", {7'd0, ovf}, 8'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_ovf_sticky", {7'd0, ovf}, 8'h01);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_ovf", {7'd0, ovf}, 8'h00);
        check("clr_count", count_bcd, 8'h00);

        // clr coincident with a rise: rise dropped, level stays uncounted.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pulse(1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("coll_pre_count", count_bcd, 8'h05);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("coll_count", count_bcd, 8'h00);
        check("coll_dp", {7'd0, seg_out[7]}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            check("coll_hold_count", count_bcd, 8'h00);
            check("coll_hold_dp", {7'd0, seg_out[7]}, 8'h00);
        end

        // ena low freezes everything; then reset with count 07 and DP pending.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1);
        pulse(1'b1);
        snap_seg = exp_seg();
        snap_dig = m_tens_phase ? 2'b10 : 2'b01;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0);
            check("ena_count", count_bcd, 8'h02);
            check("ena_dig", {6'd0, dig_sel}, {6'd0, snap_dig});
            check("ena_seg", seg_out, snap_seg);
        end
        for (int i = 0; i < 4; i++) pulse(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("mid_pre_count", count_bcd, 8'h07);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("mid_rst_count", count_bcd, 8'h00);
        check("mid_rst_ovf", {7'd0, ovf}, 8'h00);
        check("mid_rst_dig", {6'd0, dig_sel}, 8'h01);
        check("mid_rst_seg", seg_out, 8'h3F);

        // Randomized traffic against the reference model.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
